ks3: RTL and testbench



---
 rtl/ecc_pkg.sv | 17 +
 rtl/ks2.sv | 15 +
 rtl/ks3.sv | 44 ++++
 tb/tb_ks3.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared widths and a reference carry-less multiply for the ECC field-multiplier tree.
package ecc_pkg;

  localparam int KS3_W  = 3;
  localparam int KS3_PW = 5;

  function automatic logic [KS3_PW-1:0] gf2_clmul(input logic [KS3_W-1:0] a,
                                                  input logic [KS3_W-1:0] b);
    logic [KS3_PW-1:0] r;
    r = '0;
    for (int i = 0; i < KS3_W; i++) begin
      if (a[i]) r = r ^ (KS3_PW'(b) << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ks2.sv
// Combinational 2x2-bit carry-less Karatsuba multiplier (leaf of ks3).
module ks2 (
  input  logic [1:0] p_i,
  input  logic [1:0] q_i,
  output logic [2:0] r_o
);

  logic l_w, h_w, m_w;

  assign l_w = p_i[0] & q_i[0];
  assign h_w = p_i[1] & q_i[1];
  assign m_w = (p_i[0] ^ p_i[1]) & (q_i[0] ^ q_i[1]);
  assign r_o = {h_w, m_w ^ l_w ^ h_w, l_w};

endmodule

// File: rtl/ks3.sv
// Registered 3x3-bit carry-less multiplier, one-level Karatsuba split, unreduced 5-bit product.
module ks3
  import ecc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [KS3_W-1:0]  a,
  input  logic [KS3_W-1:0]  b,
  output logic [KS3_PW-1:0] y,
  output logic              out_valid
);

  logic [2:0]        l_w, m_w, mid_w;
  logic              h_w;
  logic [1:0]        am_w, bm_w;
  logic [KS3_PW-1:0] y_d, y_q;
  logic              vld_q;

  assign am_w = a[1:0] ^ {1'b0, a[2]};
  assign bm_w = b[1:0] ^ {1'b0, b[2]};
  assign h_w  = a[2] & b[2];

  ks2 u_ks2_l (.p_i(a[1:0]), .q_i(b[1:0]), .r_o(l_w));
  ks2 u_ks2_m (.p_i(am_w),   .q_i(bm_w),   .r_o(m_w));

  assign mid_w = m_w ^ l_w ^ {2'b00, h_w};
  assign y_d   = {h_w, 4'b0000} ^ {mid_w, 2'b00} ^ {2'b00, l_w};

  // Product register only loads on valid so idle operands never reach y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) y_q <= y_d;
    end
  end

  assign y         = y_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_ks3.sv
// Self-checking bench for ks3: directed vectors, exhaustive stream, random stream, reset cases.
module tb_ks3;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] a, b;
  logic [4:0] y;
  logic       out_valid;

  int n_tests;
  int n_fail;

  ks3 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .y(y), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial product from the definition: y[k] = XOR of a[i]&b[j], i+j=k.
  function automatic logic [4:0] ref_mul(input logic [2:0] x, input logic [2:0] z);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        r[i+j] = r[i+j] ^ (x[i] & z[j]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one input set after a falling edge, sample 1ns after the next rising edge.
  task automatic cyc(input logic v, input logic [2:0] av, input logic [2:0] bv);
    @(negedge clk);
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [2:0] a; logic [2:0] b; logic [4:0] y; } vec_t;
  vec_t dir_q[$];

  logic [4:0] hold;
  logic [4:0] ya;

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    #12;
    chk("reset_y", y, 5'b00000);
    chk("reset_vld", {4'b0, out_valid}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset with a nonzero product held.
    cyc(1'b1, 3'b111, 3'b111);
    chk("pre_rst_y", y, 5'b10101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", y, 5'b00000);
    chk("async_rst_vld", {4'b0, out_valid}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    dir_q.push_back('{3'b101, 3'b011, 5'b01111});
    dir_q.push_back('{3'b111, 3'b011, 5'b01001});
    dir_q.push_back('{3'b110, 3'b011, 5'b01010});
    dir_q.push_back('{3'b100, 3'b011, 5'b01100});
    dir_q.push_back('{3'b000, 3'b011, 5'b00000});
    dir_q.push_back('{3'b111, 3'b111, 5'b10101});
    dir_q.push_back('{3'b100, 3'b100, 5'b10000});
    dir_q.push_back('{3'b001, 3'b101, 5'b00101});
    dir_q.push_back('{3'b101, 3'b001, 5'b00101});
    foreach (dir_q[i]) begin
      cyc(1'b1, dir_q[i].a, dir_q[i].b);
      chk($sformatf("dir_%0d_y", i), y, dir_q[i].y);
      chk($sformatf("dir_%0d_vld", i), {4'b0, out_valid}, 5'd1);
    end

    // Swap symmetry on the corner pairs.
    cyc(1'b1, 3'b110, 3'b011);
    ya = y;
    cyc(1'b1, 3'b011, 3'b110);
    chk("swap_y", y, ya);

    // Valid gating: idle cycle holds the last product.
    cyc(1'b1, 3'b011, 3'b011);
    chk("gate_load_y", y, 5'b00101);
    cyc(1'b0, 3'b111, 3'b111);
    chk("gate_hold_y", y, 5'b00101);
    chk("gate_hold_vld", {4'b0, out_valid}, 5'd0);

    // Exhaustive back-to-back stream.
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, 3'(i >> 3), 3'(i));
      chk($sformatf("exh_%0d_y", i), y, ref_mul(3'(i >> 3), 3'(i)));
      chk($sformatf("exh_%0d_vld", i), {4'b0, out_valid}, 5'd1);
    end

    // Random valid/idle stream against the model.
    hold = y;
    for (int i = 0; i < 200; i++) begin
      logic       v;
      logic [2:0] ra, rb;
      v  = 1'($urandom_range(0, 3) != 0);
      ra = 3'($urandom);
      rb = 3'($urandom);
      cyc(v, ra, rb);
      if (v) hold = ref_mul(ra, rb);
      chk($sformatf("rnd_%0d_y", i), y, hold);
      chk($sformatf("rnd_%0d_vld", i), {4'b0, out_valid}, {4'b0, v});
    end

    // Mid-stream reset drops the in-flight product.
    cyc(1'b1, 3'b111, 3'b101);
    chk("mid_pre_y", y, ref_mul(3'b111, 3'b101));
    @(negedge clk);
    in_valid = 1'b1;
    a        = 3'b110;
    b        = 3'b110;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_y", y, 5'b00000);
    chk("mid_rst_vld", {4'b0, out_valid}, 5'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_idle_y", y, 5'b00000);
    chk("mid_idle_vld", {4'b0, out_valid}, 5'd0);
    cyc(1'b1, 3'b011, 3'b101);
    chk("mid_first_y", y, ref_mul(3'b011, 3'b101));
    chk("mid_first_vld", {4'b0, out_valid}, 5'd1);
    cyc(1'b0, 3'b000, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
